// File: rtl/divv_pkg.sv
// divv_pkg: shared definitions for the divv sequential divider.
//   DIVV_NUM_W : default dividend / quotient width
//   DIVV_DEN_W : default divisor / remainder width
//   DIVV_CNT_W : iteration counter width, wide enough to hold NUM_W
//   state_t    : controller states (IDLE, RUN, DONE)
package divv_pkg;

   localparam int DIVV_NUM_W = 20;
   localparam int DIVV_DEN_W = 10;

   // The counter must represent NUM_W itself, not just NUM_W-1.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int DIVV_CNT_W = cnt_width(DIVV_NUM_W);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/divv_step.sv
// divv_step: one restoring shift/compare/subtract iteration.
//   pr      : current partial remainder (DEN_W+1 bits)
//   bit_in  : dividend bit shifted into the partial remainder
//   den     : divisor
//   pr_next : partial remainder after this iteration
//   q_bit   : quotient bit produced by this iteration
module divv_step
   import divv_pkg::*;
#(
   parameter int DEN_W = DIVV_DEN_W
) (
   input  logic [DEN_W:0]   pr,
   input  logic             bit_in,
   input  logic [DEN_W-1:0] den,
   output logic [DEN_W:0]   pr_next,
   output logic             q_bit
);

   logic [DEN_W:0] pr_shift;
   logic [DEN_W:0] den_ext;

   // The compare runs one bit wider than the divisor so the bit pushed out
   // of the top of the old remainder still takes part in the comparison.
   always_comb begin
      pr_shift = {pr[DEN_W-1:0], bit_in};
      den_ext  = {1'b0, den};
      q_bit    = (pr_shift >= den_ext);
      pr_next  = q_bit ? (pr_shift - den_ext) : pr_shift;
   end

endmodule

// File: rtl/divv.sv
// divv: sequential unsigned restoring divider, one quotient bit per clock.
//   clk         : rising-edge clock
//   reset       : asynchronous, active-low reset
//   start       : request, only looked at while idle
//   num, den    : dividend and divisor, captured when start is accepted
//   busy        : high while a division is running or completing
//   done        : one-cycle pulse when results become valid
//   quotient    : result, held until the next completed division
//   remainder   : result, held until the next completed division
//   div_by_zero : flags a zero divisor, held with the results
module divv
   import divv_pkg::*;
#(
   parameter int NUM_W = DIVV_NUM_W,
   parameter int DEN_W = DIVV_DEN_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] quotient,
   output logic [DEN_W-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = cnt_width(NUM_W);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_W-1:0]   dvd_q, dvd_d;
   logic [DEN_W-1:0]   den_q, den_d;
   logic [DEN_W:0]     pr_q, pr_d;
   logic [NUM_W-1:0]   quotient_q, quotient_d;
   logic [DEN_W-1:0]   remainder_q, remainder_d;
   logic               dbz_q, dbz_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic [DEN_W:0]     step_pr_next;
   logic               step_q_bit;

   divv_step #(
      .DEN_W (DEN_W)
   ) u_step (
      .pr      (pr_q),
      .bit_in  (dvd_q[NUM_W-1]),
      .den     (den_q),
      .pr_next (step_pr_next),
      .q_bit   (step_q_bit)
   );

   // The dividend register doubles as the quotient register: each RUN
   // cycle its MSB feeds the step and the new quotient bit enters at the
   // LSB. Visible results only change on the cycle that enters DONE, so
   // intermediate shift values never reach the outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      den_d       = den_q;
      pr_d        = pr_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (den == '0) begin
                  quotient_d  = '1;
                  remainder_d = '0;
                  dbz_d       = 1'b1;
                  done_d      = 1'b1;
                  state_d     = ST_DONE;
               end else begin
                  dvd_d   = num;
                  den_d   = den;
                  pr_d    = '0;
                  cnt_d   = CNT_W'(NUM_W);
                  dbz_d   = 1'b0;
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            pr_d  = step_pr_next;
            dvd_d = {dvd_q[NUM_W-2:0], step_q_bit};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               quotient_d  = {dvd_q[NUM_W-2:0], step_q_bit};
               remainder_d = step_pr_next[DEN_W-1:0];
               done_d      = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         den_q       <= '0;
         pr_q        <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         den_q       <= den_d;
         pr_q        <= pr_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divv.sv
// tb_divv: self-checking bench for the divv divider and its divv_step
// iteration, comparing against plain integer division.
module tb_divv;
   import divv_pkg::*;

   localparam int NW = DIVV_NUM_W;
   localparam int DW = DIVV_DEN_W;

   logic          clk;
   logic          reset;
   logic          start;
   logic [NW-1:0] num;
   logic [DW-1:0] den;
   logic          busy;
   logic          done;
   logic [NW-1:0] quotient;
   logic [DW-1:0] remainder;
   logic          div_by_zero;

   logic [DW:0]   step_pr;
   logic          step_bit;
   logic [DW-1:0] step_den;
   logic [DW:0]   step_pr_next;
   logic          step_q;

   int errors = 0;
   int checks = 0;

   divv dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .num         (num),
      .den         (den),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   divv_step u_step (
      .pr      (step_pr),
      .bit_in  (step_bit),
      .den     (step_den),
      .pr_next (step_pr_next),
      .q_bit   (step_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Pulse start for one cycle, scramble the inputs afterwards, and wait
   // (bounded) for done. cyc is the number of negedges from accept to the
   // one showing done (-1 on timeout); busy_cnt counts negedges with busy.
   task automatic do_div(input logic [NW-1:0] n, input logic [DW-1:0] d,
                         output int cyc, output int busy_cnt);
      @(negedge clk);
      num   = n;
      den   = d;
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      num      = NW'($urandom);
      den      = DW'($urandom);
      cyc      = 1;
      busy_cnt = busy ? 1 : 0;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (busy) busy_cnt++;
      end
      if (!done) cyc = -1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      num   = '0;
      den   = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
                  busy, done, div_by_zero, quotient, remainder);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, quotient, remainder} !== '0) begin
         errors++;
         $display("[TB] FAIL after_reset_idle: got busy=%b done=%b q=%0d r=%0d, want all 0",
                  busy, done, quotient, remainder);
      end
   endtask

   task automatic test_step();
      int d, p, b, sh, exp_q, exp_next;
      for (int i = 0; i < 40; i++) begin
         d = (i < 4) ? ((i < 2) ? 1 : 1023) : $urandom_range(1, 1023);
         p = (i % 2 == 0) ? d - 1 : $urandom_range(0, d - 1);
         b = (i < 4) ? 1 : $urandom_range(0, 1);
         step_pr  = (DW+1)'(p);
         step_bit = b[0];
         step_den = DW'(d);
         #1;
         sh       = 2 * p + b;
         exp_q    = (sh >= d) ? 1 : 0;
         exp_next = exp_q ? sh - d : sh;
         checks++;
         if (step_q !== exp_q[0] || step_pr_next !== (DW+1)'(exp_next)) begin
            errors++;
            $display("[TB] FAIL step pr=%0d bit=%0d den=%0d: got q=%b next=%0d, want q=%0d next=%0d",
                     p, b, d, step_q, step_pr_next, exp_q, exp_next);
         end
      end
   endtask

   task automatic test_basic();
      int cyc, bc;
      do_div(20'd1000, 10'd7, cyc, bc);
      checks++;
      if (cyc !== 21) begin
         errors++;
         $display("[TB] FAIL basic_latency: got %0d cycles, want 21", cyc);
      end
      checks++;
      if (quotient !== 20'd142 || remainder !== 10'd6 || div_by_zero !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_result: got q=%0d r=%0d dbz=%b, want 142 6 0",
                  quotient, remainder, div_by_zero);
      end
      checks++;
      if (bc !== 21) begin
         errors++;
         $display("[TB] FAIL basic_busy_len: got %0d busy cycles, want 21", bc);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || quotient !== 20'd142 || remainder !== 10'd6) begin
         errors++;
         $display("[TB] FAIL basic_after_done: got done=%b busy=%b q=%0d r=%0d, want 0 0 142 6",
                  done, busy, quotient, remainder);
      end
   endtask

   task automatic test_edges();
      logic [NW-1:0] tn [4];
      logic [DW-1:0] td [4];
      logic [NW-1:0] tq [4];
      logic [DW-1:0] tr [4];
      int cyc, bc;
      tn[0] = 20'd1048575; td[0] = 10'd1;    tq[0] = 20'd1048575; tr[0] = 10'd0;
      tn[1] = 20'd1048575; td[1] = 10'd1000; tq[1] = 20'd1048;    tr[1] = 10'd575;
      tn[2] = 20'd5;       td[2] = 10'd1023; tq[2] = 20'd0;       tr[2] = 10'd5;
      tn[3] = 20'd0;       td[3] = 10'd9;    tq[3] = 20'd0;       tr[3] = 10'd0;
      for (int i = 0; i < 4; i++) begin
         do_div(tn[i], td[i], cyc, bc);
         checks++;
         if (cyc !== 21 || quotient !== tq[i] || remainder !== tr[i] || div_by_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL edge_%0d %0d/%0d: got q=%0d r=%0d dbz=%b cyc=%0d, want q=%0d r=%0d dbz=0 cyc=21",
                     i, tn[i], td[i], quotient, remainder, div_by_zero, cyc, tq[i], tr[i]);
         end
      end
   endtask

   task automatic test_div_by_zero();
      int cyc, bc;
      do_div(20'd1234, 10'd0, cyc, bc);
      checks++;
      if (cyc !== 1 || bc !== 1) begin
         errors++;
         $display("[TB] FAIL dbz_latency: got cyc=%0d busy=%0d, want 1 1", cyc, bc);
      end
      checks++;
      if (quotient !== 20'hFFFFF || remainder !== 10'd0 || div_by_zero !== 1'b1) begin
         errors++;
         $display("[TB] FAIL dbz_result: got q=%h r=%0d dbz=%b, want fffff 0 1",
                  quotient, remainder, div_by_zero);
      end
      do_div(20'd100, 10'd10, cyc, bc);
      checks++;
      if (cyc !== 21 || quotient !== 20'd10 || remainder !== 10'd0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dbz_clear: got q=%0d r=%0d dbz=%b cyc=%0d, want 10 0 0 21",
                  quotient, remainder, div_by_zero, cyc);
      end
   endtask

   task automatic test_ignored_start();
      int done_cnt, cyc, bc;
      logic [NW-1:0] got_q;
      logic [DW-1:0] got_r;
      done_cnt = 0;
      got_q    = '0;
      got_r    = '0;
      @(negedge clk);
      num   = 20'd1000;
      den   = 10'd7;
      start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 5) begin
            num   = 20'd100;
            den   = 10'd3;
            start = 1'b1;
         end
         if (done) begin
            done_cnt++;
            got_q = quotient;
            got_r = remainder;
         end
      end
      start = 1'b0;
      checks++;
      if (done_cnt !== 1 || got_q !== 20'd142 || got_r !== 10'd6) begin
         errors++;
         $display("[TB] FAIL ignored_start: got dones=%0d q=%0d r=%0d, want 1 142 6",
                  done_cnt, got_q, got_r);
      end
      do_div(20'd100, 10'd3, cyc, bc);
      checks++;
      if (cyc !== 21 || quotient !== 20'd33 || remainder !== 10'd1) begin
         errors++;
         $display("[TB] FAIL retry_result: got q=%0d r=%0d cyc=%0d, want 33 1 21",
                  quotient, remainder, cyc);
      end
   endtask

   task automatic test_mid_reset();
      int cyc, bc;
      @(negedge clk);
      num   = 20'd1000;
      den   = 10'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
         errors++;
         $display("[TB] FAIL async_reset: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
                  busy, done, div_by_zero, quotient, remainder);
      end
      @(negedge clk);
      reset = 1'b1;
      do_div(20'd30, 10'd4, cyc, bc);
      checks++;
      if (cyc !== 21 || quotient !== 20'd7 || remainder !== 10'd2) begin
         errors++;
         $display("[TB] FAIL post_reset_run: got q=%0d r=%0d cyc=%0d, want 7 2 21",
                  quotient, remainder, cyc);
      end
   endtask

   task automatic test_round_trip();
      int x, y, cyc, bc;
      for (int i = 0; i < 200; i++) begin
         x = $urandom_range(0, 1023);
         y = $urandom_range(1, 1023);
         do_div(NW'(x * y), DW'(y), cyc, bc);
         checks++;
         if (cyc !== 21 || quotient !== NW'(x) || remainder !== '0) begin
            errors++;
            $display("[TB] FAIL round_trip %0d*%0d/%0d: got q=%0d r=%0d cyc=%0d, want %0d 0 21",
                     x, y, y, quotient, remainder, cyc, x);
         end
      end
   endtask

   task automatic test_random();
      int n, d, eq, er, ez, ec, cyc, bc;
      for (int i = 0; i < 40; i++) begin
         n = $urandom_range(0, (1 << NW) - 1);
         d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, (1 << DW) - 1);
         if (d == 0) begin
            eq = (1 << NW) - 1; er = 0; ez = 1; ec = 1;
         end else begin
            eq = n / d; er = n % d; ez = 0; ec = 21;
         end
         do_div(NW'(n), DW'(d), cyc, bc);
         checks++;
         if (cyc !== ec || quotient !== NW'(eq) || remainder !== DW'(er) || div_by_zero !== ez[0]) begin
            errors++;
            $display("[TB] FAIL random %0d/%0d: got q=%0d r=%0d dbz=%b cyc=%0d, want %0d %0d %0d %0d",
                     n, d, quotient, remainder, div_by_zero, cyc, eq, er, ez, ec);
         end
      end
   endtask

   initial begin
      test_reset();
      test_step();
      test_basic();
      test_edges();
      test_div_by_zero();
      test_ignored_start();
      test_mid_reset();
      test_round_trip();
      test_random();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
